pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised successor to the fetch/decode boundary register: a generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
- Upstream sees a registered ready, with no combinational ready path through the stage.
- Flush inserts a bubble payload, e.g. ADDI x0,x0,0 plus zeroed side-band.
- Sits between any two core stages (IF/ID, ID/EX, ...); the payload (pc, instr, prediction bits) is packed by the instantiating stage.

Parameters:
- DATA_W, 65, payload width in bits (default: pc 32 + instr 32 + predicted_taken 1).
- BUBBLE_VAL, {32'h0, 32'h00000013, 1'b0}, payload driven on out_data whenever the stage holds no valid entry.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all held entries and insert a bubble
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat (registered)
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_W  downstream payload (registered)
- occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=EMPTY, out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0.
  - Skid entry is invalidated; counters are cleared.
- Handshake terms:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
- Latency: a beat accepted in cycle N appears on out_data in cycle N+1 if the main entry is free or being consumed. Full throughput of 1 beat/cycle when out_ready=1.
- States, with priority flush > handshake:
  - EMPTY (occupancy 0):
    - accept -> BUSY, main<=in_data.
    - Otherwise stay.
  - BUSY (occupancy 1):
    - accept & consume -> BUSY, main<=in_data.
    - accept & !consume -> FULL, skid<=in_data.
    - !accept & consume -> EMPTY, out_data<=BUBBLE_VAL.
    - Neither -> hold.
  - FULL (occupancy 2, in_ready=0):
    - consume -> BUSY, main<=skid, skid invalidated.
    - Otherwise hold.
- in_ready is the registered value of (next state != FULL). It never depends combinationally on out_ready.
- Stall: while out_valid=1 and out_ready=0, out_data and out_valid must remain stable.
- Flush, same cycle as any handshake:
  - Next state=EMPTY, out_valid=0, out_data=BUBBLE_VAL, in_ready=1.
  - A beat offered in the flush cycle is dropped, even though in_ready may read 1.
  - A downstream consume in the flush cycle is still a valid transfer of the current out_data.
- Ordering: beats exit strictly in acceptance order; no beat is duplicated or lost except via flush.
- Invariants:
  - out_data==BUBBLE_VAL whenever out_valid=0.
  - occupancy==0/1/2 exactly matches EMPTY/BUSY/FULL.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[CNT_W] and flush_cnt[CNT_W], both reset to 0.
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1.
  - Both saturate at all-ones; no wrap.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding typedef (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2);
  - NOP_INSTR=32'h00000013;
  - IF/ID payload field offsets (PC_LSB, INSTR_LSB, PRED_BIT) and the derived default BUBBLE_VAL.
- One natural sub-module: pipe_sat_counter (saturating CNT_W counter with enable and clear), instantiated twice under the macro.

Test Plan:
- Reset then idle -> out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0. Assert rst_n mid-FULL -> same values immediately, without waiting for a clock edge.
- Streaming: in_valid=1 with payloads 0x1000_0000_0000_0001 .. 0x...0008, out_ready=1 -> identical sequence one cycle later, no bubbles, in_ready constant 1.
- Backpressure: out_ready=0 for 3 cycles while beats A, B, C are offered -> A held on out_data, B taken into skid, in_ready=0 from the cycle after B, occupancy=2, C not accepted. out_ready=1 -> A, B, C emerge in order.
- Flush in FULL with in_valid=1 (beat D) -> next cycle out_valid=0, out_data=BUBBLE_VAL (instr field 0x00000013, pred bit 0), in_ready=1, D never appears.
- Flush and consume in same cycle in BUSY -> current beat counted as transferred downstream, then bubble. With PIPE_STAGE_STATS_EN: flush_cnt=1.
- With CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: state encoding, NOP encoding and IF/ID payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // IF/ID payload layout: {pc[31:0], instr[31:0], predicted_taken}
  localparam int IFID_W    = 65;
  localparam int PRED_BIT  = 0;
  localparam int INSTR_LSB = 1;
  localparam int PC_LSB    = 33;

  localparam logic [IFID_W-1:0] IFID_BUBBLE = {32'h0, NOP_INSTR, 1'b0};

  function automatic logic [IFID_W-1:0] pack_ifid(input logic [31:0] pc,
                                                  input logic [31:0] instr,
                                                  input logic        pred);
    logic [IFID_W-1:0] p;
    p = '0;
    p[PC_LSB +: 32]    = pc;
    p[INSTR_LSB +: 32] = instr;
    p[PRED_BIT]        = pred;
    return p;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic pipeline stage register with a 2-entry skid buffer and registered upstream ready.
// Optional statistics counters are enabled with `define PIPE_STAGE_STATS_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = IFID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(IFID_BUBBLE),
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if (CNT_W < 1 || DATA_W < 1) begin : g_param_check
    $error("pipe_skid_stage: DATA_W and CNT_W must be positive");
  end

  // Handshake: a beat moves on a side only in a cycle where both valid and ready
  // are high at the rising edge. in_ready is a flop (no path from out_ready);
  // out_valid/out_data are held stable while out_ready is low.
  stage_state_t      state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;
  logic              accept;
  logic              consume;

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = in_ready_q;
  assign occupancy = state;

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // A beat offered now is dropped; a consume now has already transferred out_data.
      state      <= ST_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state  <= ST_BUSY;
            main_q <= in_data;
          end
          in_ready_q <= 1'b1;
        end
        ST_BUSY: begin
          if (accept && consume) begin
            main_q     <= in_data;
            in_ready_q <= 1'b1;
          end else if (accept) begin
            state      <= ST_FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end else if (consume) begin
            state      <= ST_EMPTY;
            main_q     <= BUBBLE_VAL;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_FULL: begin
          // in_ready_q is low here, so no accept can coincide with draining the skid.
          if (consume) begin
            state      <= ST_BUSY;
            main_q     <= skid_q;
            skid_q     <= BUBBLE_VAL;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          main_q     <= BUBBLE_VAL;
          skid_q     <= BUBBLE_VAL;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (flush),
    .cnt   (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus randomized traffic against a queue model.
module tb_pipe_skid_stage;

  localparam int DATA_W = 65;
  localparam logic [DATA_W-1:0] BUBBLE = {32'h0, 32'h00000013, 1'b0};
`ifdef PIPE_STAGE_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  pipe_skid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // clock/reset
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: queue of held beats (front = beat on out_data)
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              m_ready = 1'b1;
  int                m_stall = 0;
  int                m_flush = 0;

  function automatic logic [DATA_W-1:0] m_data();
    return (exp_q.size() != 0) ? exp_q[0] : BUBBLE;
  endfunction

  function automatic logic [DATA_W+3:0] m_view();
    return {exp_q.size() != 0, m_ready, 2'(exp_q.size()), m_data()};
  endfunction

  // advance one clock, updating the model from the inputs held over the edge
  task automatic tick();
    logic              acc;
    logic              cons;
    logic [DATA_W-1:0] seen;
    acc  = in_valid & m_ready;
    cons = (exp_q.size() != 0) & out_ready;
    seen = out_data;
    @(posedge clk);
    if (cons) got_q.push_back(seen);
    if ((exp_q.size() != 0) && !out_ready && m_stall < CNT_MAX) m_stall++;
    if (flush && m_flush < CNT_MAX) m_flush++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(in_data);
    end
    m_ready = (exp_q.size() < 2);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    got_q.delete();
    m_ready = 1'b1;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (2) tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== BUBBLE) begin tests_failed++; $display("FAIL reset_out_data: got %h want %h", out_data, BUBBLE); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++;
    if (occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
`ifdef PIPE_STAGE_STATS_EN
    tests_run++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] pay;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      pay = 65'h1000_0000_0000_0000 | 65'(k);
      in_valid = 1'b1;
      in_data = pay;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== pay || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_beat%0d: got v=%b d=%h r=%b want v=1 d=%h r=1", k, out_valid, out_data, in_ready, pay);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (got_q.size() != 8) begin
      tests_failed++; $display("FAIL stream_count: got %0d want 8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        pay = 65'h1000_0000_0000_0000 | 65'(k + 1);
        tests_run++;
        if (got_q[k] !== pay) begin
          tests_failed++; $display("FAIL stream_order%0d: got %h want %h", k, got_q[k], pay);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] a, b, c;
    a = 65'h0_AAAA_0000_0000_00A1;
    b = 65'h1_BBBB_0000_0000_00B2;
    c = 65'h0_CCCC_0000_0000_00C3;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    tick();
    tests_run++;
    if (out_data !== a || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_take_a: got d=%h occ=%0d r=%b want d=%h occ=1 r=1", out_data, occupancy, in_ready, a);
    end
    in_data = b;
    tick();
    tests_run++;
    if (out_data !== a || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_take_b: got d=%h occ=%0d r=%b want d=%h occ=2 r=0", out_data, occupancy, in_ready, a);
    end
    in_data = c;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== a || occupancy !== 2'd2 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_refuse_c: got v=%b d=%h occ=%0d r=%b want v=1 d=%h occ=2 r=0", out_valid, out_data, occupancy, in_ready, a);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data !== b || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_drain_b: got d=%h occ=%0d r=%b want d=%h occ=1 r=1", out_data, occupancy, in_ready, b);
    end
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (got_q.size() != 3 || got_q[0] !== a || got_q[1] !== b || got_q[2] !== c) begin
      tests_failed++; $display("FAIL bp_order: got %0d beats want A,B,C = %h %h %h", got_q.size(), a, b, c);
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0) begin
      tests_failed++; $display("FAIL bp_empty: got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, BUBBLE);
    end
  endtask

  task automatic test_flush_full();
    logic [DATA_W-1:0] d;
    logic [31:0]       instr_f;
    d = 65'h1_DDDD_DDDD_DDDD_DDDD;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 65'h0_1111_0000_0000_0001;
    tick();
    in_data = 65'h0_2222_0000_0000_0002;
    tick();
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_full: got %0d want 2", occupancy); end
    flush = 1'b1;
    in_data = d;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    instr_f = out_data[32:1];
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      tests_failed++; $display("FAIL flush_full_state: got v=%b d=%h r=%b occ=%0d want v=0 d=%h r=1 occ=0", out_valid, out_data, in_ready, occupancy, BUBBLE);
    end
    tests_run++;
    if (instr_f !== 32'h00000013 || out_data[0] !== 1'b0) begin
      tests_failed++; $display("FAIL flush_bubble_fields: got instr=%h pred=%b want 00000013 0", instr_f, out_data[0]);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_drop_d: got %0d beats out, v=%b want 0 beats v=0", got_q.size(), out_valid);
    end
  endtask

  task automatic test_flush_consume();
    logic [DATA_W-1:0] e;
    e = 65'h0_EEEE_0000_1234_5678;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = e;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== e) begin
      tests_failed++; $display("FAIL flush_consume_xfer: got %0d beats want 1 beat %h", got_q.size(), e);
    end
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || occupancy !== 2'd0) begin
      tests_failed++; $display("FAIL flush_consume_bubble: got v=%b d=%h occ=%0d want v=0 d=%h occ=0", out_valid, out_data, occupancy, BUBBLE);
    end
`ifdef PIPE_STAGE_STATS_EN
    tests_run++;
    if (flush_cnt !== CNT_W'(1)) begin
      tests_failed++; $display("FAIL flush_cnt_one: got %0d want 1", flush_cnt);
    end
`endif
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stall_saturation();
    do_reset();
    in_valid = 1'b1;
    in_data = 65'h0_5555_0000_0000_0055;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) begin
        tests_run++;
        if (stall_cnt !== CNT_W'(10)) begin tests_failed++; $display("FAIL stall_cnt_mid: got %0d want 10", stall_cnt); end
      end
    end
    tests_run++;
    if (stall_cnt !== CNT_W'(15) || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_cnt_sat: got %0d v=%b want 15 v=1", stall_cnt, out_valid);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_data   = {$urandom(), $urandom(), 1'($urandom_range(0, 1))};
      tick();
      tests_run++;
      if ({out_valid, in_ready, occupancy, out_data} !== m_view()) begin
        tests_failed++;
        $display("FAIL random_cycle%0d: got v=%b r=%b occ=%0d d=%h want %h", i, out_valid, in_ready, occupancy, out_data, m_view());
      end
`ifdef PIPE_STAGE_STATS_EN
      tests_run++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        tests_failed++;
        $display("FAIL random_cnt%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset_full();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 65'h0_7777_0000_0000_0077;
    tick();
    in_data = 65'h0_8888_0000_0000_0088;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (occupancy !== 2'd2) begin tests_failed++; $display("FAIL async_pre_full: got %0d want 2", occupancy); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== BUBBLE || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      tests_failed++; $display("FAIL async_reset: got v=%b d=%h r=%b occ=%0d want v=0 d=%h r=1 occ=0", out_valid, out_data, in_ready, occupancy, BUBBLE);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_full();
    test_flush_consume();
`ifdef PIPE_STAGE_STATS_EN
    test_stall_saturation();
`endif
    test_random();
    test_async_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
